// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencing controller: PC write/select, imem request and IF/ID
// latch control, arbitrating branch redirect, hazard stall and variable-latency memory.
module fetch_ctrl #(
    parameter int BOOT_CYCLES = 2,
    parameter int MAX_WAIT    = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             imem_ready,
    output logic             imem_req,
    output logic             pc_we,
    output logic             pc_src,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             fetch_busy,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_count,
    output logic [2:0]       state_dbg
);

    localparam logic [2:0] S_BOOT  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT);

    logic [2:0]       state, state_nxt;
    logic [3:0]       boot_cnt, boot_nxt;
    logic [7:0]       wait_cnt, wait_nxt;
    logic [CNT_W-1:0] count_q;
    logic             err_q;
    logic             count_inc;

    always_comb begin
        state_nxt  = state;
        boot_nxt   = boot_cnt;
        wait_nxt   = wait_cnt;
        count_inc  = 1'b0;
        imem_req   = 1'b0;
        pc_we      = 1'b0;
        pc_src     = 1'b0;
        ifid_we    = 1'b0;
        ifid_flush = 1'b0;
        fetch_busy = 1'b0;
        case (state)
            S_BOOT: begin
                if (boot_cnt == BOOT_LAST) begin
                    state_nxt = S_FETCH;
                    boot_nxt  = 4'd0;
                end else begin
                    boot_nxt = boot_cnt + 4'd1;
                end
            end
            S_FETCH, S_WAIT: begin
                imem_req   = 1'b1;
                fetch_busy = (state == S_WAIT);
                if (branch_taken) begin
                    pc_we      = 1'b1;
                    pc_src     = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (imem_ready) begin
                    // A stalled completion discards the data; HOLD refetches the same PC.
                    if (stall) begin
                        state_nxt = S_HOLD;
                    end else begin
                        pc_we     = 1'b1;
                        ifid_we   = 1'b1;
                        count_inc = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else if (state == S_FETCH) begin
                    state_nxt = S_WAIT;
                    wait_nxt  = 8'd1;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end else begin
                    wait_nxt = wait_cnt + 8'd1;
                end
            end
            S_HOLD: begin
                if (branch_taken) begin
                    pc_we      = 1'b1;
                    pc_src     = 1'b1;
                    ifid_flush = 1'b1;
                    state_nxt  = S_FETCH;
                end else if (!stall) begin
                    state_nxt = S_FETCH;
                end
            end
            default: ;
        endcase
        if (rst) begin
            imem_req   = 1'b0;
            pc_we      = 1'b0;
            pc_src     = 1'b0;
            ifid_we    = 1'b0;
            ifid_flush = 1'b0;
            fetch_busy = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_BOOT;
            boot_cnt <= 4'd0;
            wait_cnt <= 8'd0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            boot_cnt <= boot_nxt;
            wait_cnt <= wait_nxt;
            if (count_inc) count_q <= count_q + 1'b1;
            if (state_nxt == S_ERR) err_q <= 1'b1;
        end
    end

    assign fetch_count = count_q;
    assign fetch_err   = err_q;
    assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Randomized scoreboard bench for fetch_ctrl: a behavioural model predicts every cycle's
// outputs, the driver queues them and a negedge monitor compares against the DUT.
module tb_fetch_ctrl;

    localparam int BOOT_CYCLES = 2;
    localparam int MAX_WAIT    = 15;
    localparam int CNT_W       = 8;
    localparam int W           = 7 + CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             stall = 1'b0;
    logic             branch_taken = 1'b0;
    logic             imem_ready = 1'b0;
    logic             imem_req, pc_we, pc_src, ifid_we, ifid_flush, fetch_busy, fetch_err;
    logic [CNT_W-1:0] fetch_count;
    logic [2:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    fetch_ctrl #(.BOOT_CYCLES(BOOT_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .imem_req(imem_req), .pc_we(pc_we), .pc_src(pc_src),
        .ifid_we(ifid_we), .ifid_flush(ifid_flush), .fetch_busy(fetch_busy),
        .fetch_err(fetch_err), .fetch_count(fetch_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: boot countdown, outstanding-wait length, held flag, dead flag.
    int boot_left = BOOT_CYCLES;
    int wait_len  = 0;
    bit holding   = 0;
    bit dead      = 0;
    bit m_err     = 0;
    int m_count   = 0;

    task automatic model_step(input bit r, input bit st, input bit br, input bit rdy);
        bit req = 0, we = 0, src = 0, iwe = 0, fl = 0, busy = 0;
        bit redirect = 0, complete = 0;
        int cnt_now = m_count;
        bit err_now = m_err;
        if (r) begin
            boot_left = BOOT_CYCLES; wait_len = 0; holding = 0; dead = 0;
            m_err = 0; m_count = 0;
        end else if (dead) begin
        end else if (boot_left > 0) begin
            boot_left--;
        end else if (holding) begin
            if (br) begin redirect = 1; holding = 0; end
            else if (!st) holding = 0;
        end else begin
            req  = 1;
            busy = (wait_len > 0);
            if (br) begin
                redirect = 1; wait_len = 0;
            end else if (rdy) begin
                if (st) holding = 1;
                else complete = 1;
                wait_len = 0;
            end else if (wait_len == MAX_WAIT) begin
                dead = 1; m_err = 1;
            end else begin
                wait_len++;
            end
        end
        if (redirect) begin we = 1; src = 1; fl = 1; end
        if (complete) begin
            we = 1; iwe = 1;
            m_count = (m_count + 1) % (1 << CNT_W);
        end
        exp_q.push_back({req, we, src, iwe, fl, busy, err_now, CNT_W'(cnt_now)});
    endtask

    task automatic drive(input bit r, input bit st, input bit br, input bit rdy);
        @(posedge clk);
        #1;
        rst = r; stall = st; branch_taken = br; imem_ready = rdy;
        model_step(r, st, br, rdy);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e, g;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {imem_req, pc_we, pc_src, ifid_we, ifid_flush, fetch_busy, fetch_err, fetch_count};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got req/we/src/iwe/fl/busy/err=%b cnt=%0d exp %b cnt=%0d",
                         $time, g[W-1:CNT_W], g[CNT_W-1:0], e[W-1:CNT_W], e[CNT_W-1:0]);
            end
        end
    end

    initial begin
        @(posedge clk);
        // Reset then free-running zero-wait fetch.
        drive(1, 0, 0, 1);
        repeat (14) drive(0, 0, 0, 1);
        // Three-cycle memory wait then one completion.
        repeat (3) drive(0, 0, 0, 0);
        drive(0, 0, 0, 1);
        // Branch beats stall in FETCH.
        drive(0, 1, 1, 1);
        // Stall at completion, hold, then release and refetch.
        repeat (4) drive(0, 1, 0, 1);
        repeat (3) drive(0, 0, 0, 1);
        // Branch while held.
        drive(0, 1, 0, 1);
        drive(0, 1, 1, 0);
        // Branch aborts a wait.
        repeat (2) drive(0, 0, 0, 0);
        drive(0, 0, 1, 1);
        // Memory timeout, sticky error, recovery via reset.
        repeat (22) drive(0, $urandom_range(0, 1) == 1, 0, 0);
        repeat (3) drive(0, 1, 1, 1);
        drive(1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 1);
        // Count wrap, then reset asserted mid-wait.
        repeat (270) drive(0, 0, 0, 1);
        repeat (2) drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        repeat (4) drive(0, 0, 0, 1);
        // Reset while held.
        drive(0, 1, 0, 1);
        drive(1, 1, 0, 1);
        repeat (3) drive(0, 0, 0, 1);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 75);
        end
        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
